hazard_ctrl_md: RTL and testbench
=================================

Name: hazard_ctrl_md

Overview:
Parametrised stall/forward controller for the 5-stage pipeline, successor to the current stall-only hazard unit. It generates F/D stall and E flush from Tuse/Tnew comparison, D- and E-stage forwarding selects, and a stall while the multi-cycle mult/div unit is busy. An internal busy counter tracks mult/div latency. It sits beside the datapath and drives the F/D pipeline-register enables, the D/E register clear, and the forwarding muxes.

Parameters:
REG_AW, 5, register address width; address 0 is the hard-wired zero register
T_W, 2, width of Tuse/Tnew fields
MULT_CYCLES, 5, busy cycles after a mult starts
DIV_CYCLES, 10, busy cycles after a div starts
CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
D_rs, D_rt  in  REG_AW  D-stage source addresses
Tuse_rs, Tuse_rt  in  T_W  D-stage use times
E_rs, E_rt  in  REG_AW  E-stage source addresses
E_wa, M_wa, W_wa  in  REG_AW  write addresses in E/M/W; 0 means no write
E_Tnew, M_Tnew  in  T_W  E/M result-ready times
D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_md_start  in  1  mult/div in E starts this cycle
E_md_div  in  1  qualifies E_md_start: 1 = div, 0 = mult
F_stall, D_stall, E_flush  out  1  hold F, hold D, clear D/E register
D_fwd_rs, D_fwd_rt  out  2  D forward select: 0 = GRF, 1 = M, 2 = W
E_fwd_rs, E_fwd_rt  out  2  E forward select: 0 = pipe reg, 1 = M, 2 = W
md_busy  out  1  mult/div busy
stall_cnt  out  32  stall-cycle count (feature only)

Behaviour:
- Register stall, per source s in {rs, rt}: stall_s = (D_s != 0) and ((D_s == E_wa and Tuse_s < E_Tnew) or (D_s == M_wa and Tuse_s < M_Tnew)).
- md_stall = D_md_use and (md_busy or E_md_start).
- stall = stall_rs | stall_rt | md_stall. F_stall = D_stall = E_flush = stall. All are combinational, same cycle.
- D forwarding, per source: 1 if D_s != 0, D_s == M_wa and M_Tnew == 0; else 2 if D_s != 0 and D_s == W_wa; else 0. M has priority over W.
- E forwarding: same rule using E_s. E-stage values from W are always ready.
- Busy counter, cnt of width CNT_W:
  - Reset value is 0.
  - If E_md_start: load MULT_CYCLES, or DIV_CYCLES when E_md_div is 1.
  - Else, if cnt != 0: decrement by 1.
  - md_busy = (cnt != 0), registered-derived.
  - A mult starting at cycle t gives md_busy high for cycles t+1 through t+MULT_CYCLES.
- E_md_start while md_busy reloads the counter (restart semantics). The pipeline prevents this case; there is no error flag.
- E_md_start is sampled regardless of E_flush. The instruction in E is never the one being flushed.
- Deasserting rst_n mid-operation immediately clears cnt, md_busy and stall_cnt. All combinational outputs then follow their inputs with md_busy = 0.
- Reset values: md_busy = 0 and stall_cnt = 0. The remaining outputs are combinational.

Optional Feature:
HAZARD_PERF_EN:
- Defined: a 32-bit counter increments on every clk cycle with stall = 1, wraps at 2^32, and is reset to 0. Its value is driven on stall_cnt.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_NONE = 0, FWD_M = 1, FWD_W = 2
  - the T_W-wide Tnew/Tuse typedef
  - default MULT_CYCLES and DIV_CYCLES constants
- One natural sub-module: md_busy_cnt, holding the load/decrement counter and md_busy.
- The forwarding-select logic is a function in hazard_pkg, instantiated four times.

Test Plan:
- D_rs=3, Tuse_rs=0, E_wa=3, E_Tnew=2 -> F_stall=D_stall=E_flush=1. Repeat with D_rs=0 -> all 0.
- D_rt=5, Tuse_rt=1, M_wa=5, M_Tnew=1 -> no stall. Then M_Tnew=0 -> D_fwd_rt=1. Then M_wa=0, W_wa=5 -> D_fwd_rt=2.
- E_rs=7, M_wa=7 with M_Tnew=0, and W_wa=7 -> E_fwd_rs=1 (M priority).
- E_md_start=1, E_md_div=0 at cycle t -> md_busy high for t+1..t+5. D_md_use=1 stalls cycles t..t+5 and releases at t+6. Repeat with a div: busy through t+10.
- Start a div, assert rst_n=0 at busy cycle 3 -> md_busy=0 and no stall on D_md_use after release.
- With HAZARD_PERF_EN, drive 7 stall cycles -> stall_cnt=7. Without the macro, stall_cnt stays 0.

Source files
------------

// File: rtl/hazard_ctrl_md_pkg.sv
// hazard_pkg -- shared definitions for the hazard_ctrl_md controller.
//   * forward-select encodings (FWD_NONE / FWD_M / FWD_W) and their type
//   * Tuse/Tnew value type at the default field width
//   * default mult/div busy latencies
//   * fwd_sel(): priority forward-select decode used for all four mux selects
package hazard_pkg;

  localparam int T_W_DEF         = 2;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef logic [T_W_DEF-1:0] tval_t;
  typedef logic [1:0]         fwd_t;

  localparam fwd_t FWD_NONE = 2'd0;
  localparam fwd_t FWD_M    = 2'd1;
  localparam fwd_t FWD_W    = 2'd2;

  // Address comparisons are done by the caller so this stays width-agnostic.
  // M wins over W because it holds the younger write to the same register.
  function automatic fwd_t fwd_sel(input logic src_nz, input logic m_hit,
                                   input logic m_ready, input logic w_hit);
    fwd_t sel;
    sel = FWD_NONE;
    if (src_nz && m_hit && m_ready) sel = FWD_M;
    else if (src_nz && w_hit)       sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_if.sv
// hazard_ctrl_md_if -- bundle between the datapath and hazard_ctrl_md.
//   Datapath -> controller: D/E source addresses, Tuse/Tnew times,
//     E/M/W write addresses (0 = no write), mult/div use/start/type.
//   Controller -> datapath: F_stall, D_stall, E_flush, D/E forward selects,
//     md_busy, stall_cnt.
// Modports: master = datapath side, slave = hazard controller.
interface hazard_ctrl_md_if #(
  parameter int REG_AW = 5,
  parameter int T_W    = 2
);
  logic [REG_AW-1:0] D_rs, D_rt;
  logic [T_W-1:0]    Tuse_rs, Tuse_rt;
  logic [REG_AW-1:0] E_rs, E_rt;
  logic [REG_AW-1:0] E_wa, M_wa, W_wa;
  logic [T_W-1:0]    E_Tnew, M_Tnew;
  logic              D_md_use;
  logic              E_md_start;
  logic              E_md_div;

  logic              F_stall, D_stall, E_flush;
  logic [1:0]        D_fwd_rs, D_fwd_rt;
  logic [1:0]        E_fwd_rs, E_fwd_rt;
  logic              md_busy;
  logic [31:0]       stall_cnt;

  modport master (
    output D_rs, D_rt, Tuse_rs, Tuse_rt, E_rs, E_rt, E_wa, M_wa, W_wa,
           E_Tnew, M_Tnew, D_md_use, E_md_start, E_md_div,
    input  F_stall, D_stall, E_flush, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt,
           md_busy, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, Tuse_rs, Tuse_rt, E_rs, E_rt, E_wa, M_wa, W_wa,
           E_Tnew, M_Tnew, D_md_use, E_md_start, E_md_div,
    output F_stall, D_stall, E_flush, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt,
           md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_md_md_busy_cnt.sv
// md_busy_cnt -- mult/div latency tracker.
//   clk, rst_n  : clock, asynchronous active-low reset
//   md_start    : mult/div in E starts this cycle (reloads even when busy)
//   md_div      : 1 = div latency, 0 = mult latency
//   md_busy     : counter non-zero, i.e. unit still working
// A start at cycle t raises md_busy for cycles t+1 .. t+N.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (md_start)
      cnt_next = md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign md_busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// hazard_ctrl_md -- stall/forward controller for the 5-stage pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz (slave) : datapath bundle, see hazard_ctrl_md_if
// Stall when a D-stage source needs a value that E or M will not have in
// time (Tuse < Tnew), or when a mult/div-dependent instruction meets a busy
// or starting mult/div unit. F_stall, D_stall and E_flush are all that stall.
// Optional build macro HAZARD_PERF_EN: adds a 32-bit stall-cycle counter on
// stall_cnt; without it stall_cnt is constant 0.
module hazard_ctrl_md
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_ctrl_md_if.slave   hz
);

  logic [REG_AW-1:0] d_src  [2];
  logic [T_W-1:0]    d_tuse [2];
  logic [REG_AW-1:0] e_src  [2];
  logic [1:0]        stall_src;
  fwd_t              d_fwd  [2];
  fwd_t              e_fwd  [2];
  logic              md_busy;
  logic              md_stall;
  logic              stall;

  assign d_src[0]  = hz.D_rs;
  assign d_src[1]  = hz.D_rt;
  assign d_tuse[0] = hz.Tuse_rs;
  assign d_tuse[1] = hz.Tuse_rt;
  assign e_src[0]  = hz.E_rs;
  assign e_src[1]  = hz.E_rt;

  // Index 0 = rs, 1 = rt.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign stall_src[gi] = (d_src[gi] != '0) &&
                           (((d_src[gi] == hz.E_wa) && (d_tuse[gi] < hz.E_Tnew)) ||
                            ((d_src[gi] == hz.M_wa) && (d_tuse[gi] < hz.M_Tnew)));

    assign d_fwd[gi] = fwd_sel(d_src[gi] != '0, d_src[gi] == hz.M_wa,
                               hz.M_Tnew == '0, d_src[gi] == hz.W_wa);
    assign e_fwd[gi] = fwd_sel(e_src[gi] != '0, e_src[gi] == hz.M_wa,
                               hz.M_Tnew == '0, e_src[gi] == hz.W_wa);
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (hz.E_md_start),
    .md_div   (hz.E_md_div),
    .md_busy  (md_busy)
  );

  // A start in E counts too: the counter only reflects it from next cycle.
  assign md_stall = hz.D_md_use && (md_busy || hz.E_md_start);
  assign stall    = stall_src[0] | stall_src[1] | md_stall;

  assign hz.F_stall  = stall;
  assign hz.D_stall  = stall;
  assign hz.E_flush  = stall;
  assign hz.D_fwd_rs = d_fwd[0];
  assign hz.D_fwd_rt = d_fwd[1];
  assign hz.E_fwd_rs = e_fwd[0];
  assign hz.E_fwd_rt = e_fwd[1];
  assign hz.md_busy  = md_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt_reg <= '0;
    else if (stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign hz.stall_cnt = stall_cnt_reg;
`else
  assign hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// tb_hazard_ctrl_md -- directed self-checking bench for hazard_ctrl_md.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Cycle k is the interval ending at the k-th counted rising edge.
module tb_hazard_ctrl_md;
  import hazard_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_ctrl_md_if #(.REG_AW(5), .T_W(2)) hz ();

  hazard_ctrl_md #(
    .REG_AW(5), .T_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, "_F"}, {31'd0, hz.F_stall}, {31'd0, exp});
    chk({tag, "_D"}, {31'd0, hz.D_stall}, {31'd0, exp});
    chk({tag, "_E"}, {31'd0, hz.E_flush}, {31'd0, exp});
  endtask

  task automatic clear_inputs();
    hz.D_rs = '0; hz.D_rt = '0; hz.Tuse_rs = '0; hz.Tuse_rt = '0;
    hz.E_rs = '0; hz.E_rt = '0; hz.E_wa = '0; hz.M_wa = '0; hz.W_wa = '0;
    hz.E_Tnew = '0; hz.M_Tnew = '0;
    hz.D_md_use = 1'b0; hz.E_md_start = 1'b0; hz.E_md_div = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_perf;

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", {31'd0, hz.md_busy}, 32'd0);
    chk("rst_scnt", hz.stall_cnt, 32'd0);
    chk_stall("rst_stall", 1'b0);
    chk("rst_dfwd", {30'd0, hz.D_fwd_rs}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // ---- register stall on rs ----
    hz.D_rs = 5'd3; hz.Tuse_rs = 2'd0; hz.E_wa = 5'd3; hz.E_Tnew = 2'd2;
    #1; chk_stall("rs_e_hit", 1'b1);
    chk("rs_e_dfwd", {30'd0, hz.D_fwd_rs}, 32'd0);
    hz.Tuse_rs = 2'd2;
    #1; chk_stall("rs_tuse_eq", 1'b0);
    hz.Tuse_rs = 2'd0; hz.D_rs = 5'd0;
    #1; chk_stall("rs_zero", 1'b0);
    clear_inputs();

    // ---- rt via M, then forwarding ----
    hz.D_rt = 5'd5; hz.Tuse_rt = 2'd1; hz.M_wa = 5'd5; hz.M_Tnew = 2'd1;
    #1; chk_stall("rt_m_ok", 1'b0);
    chk("rt_m_nrdy", {30'd0, hz.D_fwd_rt}, 32'd0);
    hz.Tuse_rt = 2'd0;
    #1; chk_stall("rt_m_late", 1'b1);
    hz.Tuse_rt = 2'd1; hz.M_Tnew = 2'd0;
    #1; chk("dfwd_rt_m", {30'd0, hz.D_fwd_rt}, 32'd1);
    hz.M_wa = 5'd0; hz.W_wa = 5'd5;
    #1; chk("dfwd_rt_w", {30'd0, hz.D_fwd_rt}, 32'd2);
    chk("dfwd_rs_0", {30'd0, hz.D_fwd_rs}, 32'd0);
    clear_inputs();

    // ---- E forwarding ----
    hz.E_rs = 5'd7; hz.M_wa = 5'd7; hz.M_Tnew = 2'd0; hz.W_wa = 5'd7;
    #1; chk("efwd_rs_mpri", {30'd0, hz.E_fwd_rs}, 32'd1);
    hz.M_Tnew = 2'd1;
    #1; chk("efwd_rs_w", {30'd0, hz.E_fwd_rs}, 32'd2);
    hz.E_rt = 5'd0; hz.W_wa = 5'd0;
    #1; chk("efwd_rt_zero", {30'd0, hz.E_fwd_rt}, 32'd0);
    hz.E_rt = 5'd7; hz.M_Tnew = 2'd0;
    #1; chk("efwd_rt_m", {30'd0, hz.E_fwd_rt}, 32'd1);
    clear_inputs();
    next_cycle();

    // ---- mult: busy t+1..t+5 ----
    hz.E_md_start = 1'b1; hz.E_md_div = 1'b0; hz.D_md_use = 1'b1;
    @(negedge clk);
    chk("mul_t_busy", {31'd0, hz.md_busy}, 32'd0);
    chk_stall("mul_t", 1'b1);
    next_cycle();
    hz.E_md_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy%0d", k), {31'd0, hz.md_busy}, 32'd1);
      chk($sformatf("mul_stall%0d", k), {31'd0, hz.D_stall}, 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("mul_rel_busy", {31'd0, hz.md_busy}, 32'd0);
    chk_stall("mul_rel", 1'b0);
    next_cycle();

    // ---- div: busy t+1..t+10 ----
    hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
    next_cycle();
    hz.E_md_start = 1'b0; hz.E_md_div = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("div_busy%0d", k), {31'd0, hz.md_busy}, 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("div_rel_busy", {31'd0, hz.md_busy}, 32'd0);
    chk_stall("div_rel", 1'b0);
    next_cycle();

    // ---- reset during a div ----
    hz.E_md_start = 1'b1; hz.E_md_div = 1'b1;
    next_cycle();
    hz.E_md_start = 1'b0; hz.E_md_div = 1'b0;
    next_cycle();   // busy cycle 2
    next_cycle();   // busy cycle 3
    @(negedge clk);
    chk("rdiv_pre", {31'd0, hz.md_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rdiv_async", {31'd0, hz.md_busy}, 32'd0);
    chk_stall("rdiv_inrst", 1'b0);
    chk("rdiv_scnt", hz.stall_cnt, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("rdiv_after%0d", k), {31'd0, hz.md_busy}, 32'd0);
      chk($sformatf("rdiv_nostl%0d", k), {31'd0, hz.D_stall}, 32'd0);
      next_cycle();
    end
    hz.D_md_use = 1'b0;

    // ---- perf counter: 7 stall cycles after a fresh reset ----
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    hz.D_rs = 5'd9; hz.E_wa = 5'd9; hz.E_Tnew = 2'd1; hz.Tuse_rs = 2'd0;
    repeat (7) next_cycle();
    clear_inputs();
    next_cycle();
    next_cycle();
`ifdef HAZARD_PERF_EN
    exp_perf = 32'd7;
`else
    exp_perf = 32'd0;
`endif
    @(negedge clk);
    chk("perf_cnt", hz.stall_cnt, exp_perf);
    chk_stall("perf_idle", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
